// File: rtl/keyboard_matrix.sv
// PS/2 set-2 keyboard receiver and decoder presenting a C64-style 8x8 key matrix
// to CIA1 port A/B, with F12 routed to the RESTORE line.
module keyboard_matrix #(
    parameter int TIMEOUT = 16384
) (
    input  logic       dot_clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] keyboard_ROW,
    output logic [7:0] keyboard_COL,
    output logic       restore,
    output logic       frame_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] IDLE_LIMIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    logic [1:0]      clk_sync_q, clk_sync_d;
    logic [1:0]      dat_sync_q, dat_sync_d;
    logic            clk_prev_q, clk_prev_d;
    logic [3:0]      bit_pos_q, bit_pos_d;
    logic [9:0]      frame_q, frame_d;
    logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [7:0]      byte_q, byte_d;
    logic            byte_vld_q, byte_vld_d;
    logic            frame_err_q, frame_err_d;
    state_t          state_q, state_d;
    logic [7:0][7:0] key_q, key_d;
    logic            restore_q, restore_d;

    logic        fall;
    logic [10:0] full;
    logic [6:0]  lut;
    logic        apply, make;

    // Returns {valid, row[2:0], col[2:0]} for a set-2 scan code.
    function automatic logic [6:0] key_lut(input logic [7:0] code);
        case (code)
            8'h66: key_lut = {1'b1, 3'd0, 3'd0};  8'h5A: key_lut = {1'b1, 3'd0, 3'd1};
            8'h83: key_lut = {1'b1, 3'd0, 3'd3};  8'h05: key_lut = {1'b1, 3'd0, 3'd4};
            8'h04: key_lut = {1'b1, 3'd0, 3'd5};  8'h03: key_lut = {1'b1, 3'd0, 3'd6};
            8'h26: key_lut = {1'b1, 3'd1, 3'd0};  8'h1D: key_lut = {1'b1, 3'd1, 3'd1};
            8'h1C: key_lut = {1'b1, 3'd1, 3'd2};  8'h25: key_lut = {1'b1, 3'd1, 3'd3};
            8'h1A: key_lut = {1'b1, 3'd1, 3'd4};  8'h1B: key_lut = {1'b1, 3'd1, 3'd5};
            8'h24: key_lut = {1'b1, 3'd1, 3'd6};  8'h12: key_lut = {1'b1, 3'd1, 3'd7};
            8'h2E: key_lut = {1'b1, 3'd2, 3'd0};  8'h2D: key_lut = {1'b1, 3'd2, 3'd1};
            8'h23: key_lut = {1'b1, 3'd2, 3'd2};  8'h36: key_lut = {1'b1, 3'd2, 3'd3};
            8'h21: key_lut = {1'b1, 3'd2, 3'd4};  8'h2B: key_lut = {1'b1, 3'd2, 3'd5};
            8'h2C: key_lut = {1'b1, 3'd2, 3'd6};  8'h22: key_lut = {1'b1, 3'd2, 3'd7};
            8'h3D: key_lut = {1'b1, 3'd3, 3'd0};  8'h35: key_lut = {1'b1, 3'd3, 3'd1};
            8'h34: key_lut = {1'b1, 3'd3, 3'd2};  8'h3E: key_lut = {1'b1, 3'd3, 3'd3};
            8'h32: key_lut = {1'b1, 3'd3, 3'd4};  8'h33: key_lut = {1'b1, 3'd3, 3'd5};
            8'h3C: key_lut = {1'b1, 3'd3, 3'd6};  8'h2A: key_lut = {1'b1, 3'd3, 3'd7};
            8'h46: key_lut = {1'b1, 3'd4, 3'd0};  8'h43: key_lut = {1'b1, 3'd4, 3'd1};
            8'h3B: key_lut = {1'b1, 3'd4, 3'd2};  8'h45: key_lut = {1'b1, 3'd4, 3'd3};
            8'h3A: key_lut = {1'b1, 3'd4, 3'd4};  8'h42: key_lut = {1'b1, 3'd4, 3'd5};
            8'h44: key_lut = {1'b1, 3'd4, 3'd6};  8'h31: key_lut = {1'b1, 3'd4, 3'd7};
            8'h4E: key_lut = {1'b1, 3'd5, 3'd0};  8'h4D: key_lut = {1'b1, 3'd5, 3'd1};
            8'h4B: key_lut = {1'b1, 3'd5, 3'd2};  8'h55: key_lut = {1'b1, 3'd5, 3'd3};
            8'h49: key_lut = {1'b1, 3'd5, 3'd4};  8'h4C: key_lut = {1'b1, 3'd5, 3'd5};
            8'h41: key_lut = {1'b1, 3'd5, 3'd7};  8'h59: key_lut = {1'b1, 3'd6, 3'd4};
            8'h4A: key_lut = {1'b1, 3'd6, 3'd7};  8'h16: key_lut = {1'b1, 3'd7, 3'd0};
            8'h14: key_lut = {1'b1, 3'd7, 3'd2};  8'h1E: key_lut = {1'b1, 3'd7, 3'd3};
            8'h29: key_lut = {1'b1, 3'd7, 3'd4};  8'h11: key_lut = {1'b1, 3'd7, 3'd5};
            8'h15: key_lut = {1'b1, 3'd7, 3'd6};  8'h76: key_lut = {1'b1, 3'd7, 3'd7};
            default: key_lut = 7'd0;
        endcase
    endfunction

    assign fall = clk_prev_q & ~clk_sync_q[1];
    assign full = {dat_sync_q[1], frame_q};

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        dat_sync_d  = {dat_sync_q[0], ps2_data};
        clk_prev_d  = clk_sync_q[1];
        bit_pos_d   = bit_pos_q;
        frame_d     = frame_q;
        idle_cnt_d  = idle_cnt_q;
        byte_d      = byte_q;
        byte_vld_d  = 1'b0;
        frame_err_d = 1'b0;
        if (fall) begin
            idle_cnt_d = '0;
            if (bit_pos_q == 4'd10) begin
                bit_pos_d = 4'd0;
                if (!full[0] && full[10] && (^full[9:1])) begin
                    byte_vld_d = 1'b1;
                    byte_d     = full[8:1];
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                bit_pos_d = bit_pos_q + 4'd1;
                frame_d   = {dat_sync_q[1], frame_q[9:1]};
            end
        end else if (bit_pos_q != 4'd0) begin
            // A stalled partial frame is dropped silently.
            if (idle_cnt_q == IDLE_LIMIT) begin
                bit_pos_d  = 4'd0;
                idle_cnt_d = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        restore_d = restore_q;
        apply     = 1'b0;
        make      = 1'b0;
        lut       = key_lut(byte_q);
        if (byte_vld_q) begin
            case (state_q)
                IDLE: begin
                    if (byte_q == 8'hF0)      state_d = BRK;
                    else if (byte_q == 8'hE0) state_d = EXT;
                    else begin
                        apply = 1'b1;
                        make  = 1'b1;
                    end
                end
                BRK: begin
                    apply   = 1'b1;
                    state_d = IDLE;
                end
                EXT:     state_d = (byte_q == 8'hF0) ? EXT_BRK : IDLE;
                default: state_d = IDLE;
            endcase
        end
        if (apply) begin
            if (byte_q == 8'h07)  restore_d = make;
            else if (lut[6])      key_d[lut[5:3]][lut[2:0]] = make;
        end
    end

    always_comb begin
        keyboard_COL = 8'hFF;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (!keyboard_ROW[r] && key_q[r][c]) keyboard_COL[c] = 1'b0;
    end

    always_ff @(posedge dot_clk) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            clk_prev_q  <= 1'b1;
            bit_pos_q   <= 4'd0;
            frame_q     <= '0;
            idle_cnt_q  <= '0;
            byte_q      <= 8'h00;
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            state_q     <= IDLE;
            key_q       <= '0;
            restore_q   <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            clk_prev_q  <= clk_prev_d;
            bit_pos_q   <= bit_pos_d;
            frame_q     <= frame_d;
            idle_cnt_q  <= idle_cnt_d;
            byte_q      <= byte_d;
            byte_vld_q  <= byte_vld_d;
            frame_err_q <= frame_err_d;
            state_q     <= state_d;
            key_q       <= key_d;
            restore_q   <= restore_d;
        end
    end

    assign restore   = restore_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_keyboard_matrix.sv
// Scoreboard bench for keyboard_matrix: PS/2 frames in, matrix/restore/frame_err out.
module tb_keyboard_matrix;

    localparam int TO = 200;

    logic       dot_clk = 1'b0;
    logic       reset, ps2_clk, ps2_data;
    logic [7:0] keyboard_ROW, keyboard_COL;
    logic       restore, frame_err;

    typedef struct {
        string      tag;
        logic [7:0] row;
        logic [7:0] col;
        logic       rst;
        int         errs;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0, n_bad = 0;
    int   err_total = 0, err_base = 0;

    always #5 dot_clk = ~dot_clk;

    keyboard_matrix #(.TIMEOUT(TO)) dut (
        .dot_clk(dot_clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keyboard_ROW(keyboard_ROW), .keyboard_COL(keyboard_COL),
        .restore(restore), .frame_err(frame_err)
    );

    // Counts high cycles, so a stretched pulse shows up as extra errors.
    always @(posedge dot_clk) if (frame_err === 1'b1) err_total++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (8) @(negedge dot_clk);
        ps2_clk = 1'b0;
        repeat (8) @(negedge dot_clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] v, input logic bad = 1'b0, input int nbits = 11);
        logic [10:0] bits;
        bits = {1'b1, (~^v) ^ bad, v, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
        repeat (6) @(negedge dot_clk);
    endtask

    task automatic expect_st(input string tag, input logic [7:0] row, input logic [7:0] col,
                             input logic rst, input int errs);
        exp_t e;
        e.tag = tag; e.row = row; e.col = col; e.rst = rst; e.errs = errs;
        sb_q.push_back(e);
    endtask

    task automatic check_sb();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            keyboard_ROW = e.row;
            @(negedge dot_clk);
            chk({e.tag, ".col"}, {24'd0, keyboard_COL}, {24'd0, e.col});
            chk({e.tag, ".rst"}, {31'd0, restore}, {31'd0, e.rst});
            chk({e.tag, ".err"}, err_total - err_base, e.errs);
        end
        err_base = err_total;
    endtask

    initial begin
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; keyboard_ROW = 8'h00;
        repeat (3) @(negedge dot_clk);
        chk("rst.ferr", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        expect_st("rst", 8'h00, 8'hFF, 1'b0, 0);
        check_sb();

        send(8'h1C);
        expect_st("a_fd", 8'hFD, 8'hFB, 1'b0, 0);
        expect_st("a_fe", 8'hFE, 8'hFF, 1'b0, 0);
        expect_st("a_00", 8'h00, 8'hFB, 1'b0, 0);
        check_sb();

        send(8'h12);
        expect_st("a_sh", 8'hFD, 8'h7B, 1'b0, 0);
        check_sb();
        send(8'hF0); send(8'h1C);
        expect_st("sh", 8'hFD, 8'h7F, 1'b0, 0);
        check_sb();
        send(8'hF0); send(8'h12);
        expect_st("none", 8'hFD, 8'hFF, 1'b0, 0);
        check_sb();

        send(8'h1C, 1'b1);
        expect_st("par", 8'h00, 8'hFF, 1'b0, 1);
        check_sb();
        send(8'h29);
        expect_st("space", 8'h7F, 8'hEF, 1'b0, 0);
        check_sb();
        send(8'hF0); send(8'h29);

        send(8'h33, 1'b0, 6);
        repeat (TO + 10) @(negedge dot_clk);
        send(8'h5A);
        expect_st("tmo", 8'hFE, 8'hFD, 1'b0, 0);
        check_sb();
        send(8'hF0); send(8'h5A);

        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        expect_st("ext", 8'h00, 8'hFF, 1'b0, 0);
        check_sb();
        send(8'h07);
        expect_st("rs_on", 8'h00, 8'hFF, 1'b1, 0);
        check_sb();
        send(8'hF0); send(8'h07);
        expect_st("rs_off", 8'h00, 8'hFF, 1'b0, 0);
        check_sb();

        send(8'h1C); send(8'h1C); send(8'h1C);
        expect_st("typem", 8'hFD, 8'hFB, 1'b0, 0);
        check_sb();
        send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h29);
        send(8'h7E);
        expect_st("harml", 8'h00, 8'hFF, 1'b0, 0);
        check_sb();

        send(8'h1C); send(8'h16);
        expect_st("two", 8'h7D, 8'hFA, 1'b0, 0);
        expect_st("r0", 8'hFE, 8'hFF, 1'b0, 0);
        expect_st("r7", 8'h7F, 8'hFE, 1'b0, 0);
        check_sb();
        send(8'hF0); send(8'h1C);

        send(8'h07);
        expect_st("held", 8'h7F, 8'hFE, 1'b1, 0);
        check_sb();
        send(8'h2D, 1'b0, 6);
        @(negedge dot_clk); reset = 1'b1;
        @(negedge dot_clk); reset = 1'b0;
        expect_st("rst2", 8'h00, 8'hFF, 1'b0, 0);
        check_sb();
        send(8'h16);
        expect_st("post", 8'h7F, 8'hFE, 1'b0, 0);
        check_sb();

        chk("err_total", err_total, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keyboard_matrix.md
KEYBOARD_MATRIX -- requirements
Module: keyboard_matrix

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16384, giving the dot_clk cycles without a PS/2 clock falling edge before a partial frame is abandoned.
REQ-002 The block SHALL have port dot_clk, input, 1 bit: the sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port ps2_clk, input, 1 bit: raw, asynchronous PS/2 keyboard clock.
REQ-005 The block SHALL have port ps2_data, input, 1 bit: raw, asynchronous PS/2 keyboard data.
REQ-006 The block SHALL have port keyboard_ROW, input, 8 bits: row select driven by CIA1 port A; a bit at 0 selects that row.
REQ-007 The block SHALL have port keyboard_COL, output, 8 bits: column sense returned to CIA1 port B; active-low.
REQ-008 The block SHALL have port restore, output, 1 bit: RESTORE key held, active-high, feeding the NMI input.
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a PS/2 frame is rejected.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is detected when the synchronized clock goes from 1 to 0.
REQ-011 On each falling edge the receiver SHALL sample synchronized data into an 11-bit frame: start bit, data bits 0..7 LSB first, odd parity, stop bit.
REQ-012 The frame SHALL be accepted only if start=0, stop=1 and the nine data+parity bits hold an odd number of ones.
  - An accepted frame delivers its byte to the decoder one cycle after the stop-bit edge.
REQ-013 A rejected frame SHALL pulse frame_err for 1 cycle, deliver nothing and return the receiver to the start-bit position.
REQ-014 A TIMEOUT-cycle idle counter SHALL reset on every falling edge.
  - On expiry with a frame part-received, the bit position returns to 0, frame_err stays low, and no byte is delivered.
REQ-015 The decoder FSM SHALL have states IDLE, BRK, EXT and EXT_BRK. Transitions:
  - IDLE: F0 -> BRK; E0 -> EXT; any other byte is a make code, applied, then IDLE.
  - BRK: any byte is a break code, applied, then IDLE.
  - EXT: F0 -> EXT_BRK; any other byte is ignored, then IDLE.
  - EXT_BRK: any byte is ignored, then IDLE.
REQ-016 A make code SHALL set, and a break code SHALL clear, one bit of a 64-bit key matrix indexed by (row, col) through a fixed lookup table.
  - Codes with no table entry are ignored.
  - The table SHALL include: 1C=A (1,2); 12=LShift (1,7); 29=Space (7,4); 5A=Return (0,1); 16=1 (7,0).
  - Code 07 (F12) SHALL map to RESTORE rather than to a matrix bit.
REQ-017 keyboard_COL[c] SHALL be combinational: 0 iff some row r has keyboard_ROW[r]=0 and key(r,c)=1, otherwise 1.
  - There is no ghosting suppression.
REQ-018 restore SHALL be a registered level: set by make 07 and cleared by break 07.
REQ-019 A byte arriving on the same cycle as a timeout expiry SHALL be delivered; the timeout only affects partial frames.
REQ-020 Repeated make codes (typematic) SHALL be idempotent, and a break for a key not held SHALL be harmless.

Reset
REQ-021 While reset is high, the following SHALL be cleared: synchronizers held at 1, bit position 0, idle counter 0, FSM IDLE, all 64 matrix bits 0, restore 0, frame_err 0.
  - keyboard_COL therefore reads FF for any row select.
REQ-022 Reset asserted mid-frame SHALL discard that frame.
  - The first complete frame after reset release is decoded normally.

Verification
REQ-023 Send frame 1C with ROW=FD -> COL=FB; with ROW=FE -> COL=FF; with ROW=00 -> COL=FB.
REQ-024 Send 1C and 12, then F0 1C, with ROW=FD -> COL=7F; then F0 12 -> COL=FF.
REQ-025 Send 1C with wrong parity -> frame_err pulses once and COL=FF for ROW=00.
  - A following good 29 with ROW=7F -> COL=EF.
REQ-026 Send 6 bits of a frame, idle TIMEOUT+1 cycles, then full frame 5A with ROW=FE -> COL=FD and frame_err never asserted.
REQ-027 Send E0 75 and E0 F0 75 -> matrix unchanged and COL=FF.
  - Then 07 -> restore=1; then F0 07 -> restore=0.
REQ-028 Hold 16 pressed and assert reset for 1 cycle mid-frame -> COL=FF for ROW=00 and restore=0.
  - The next 16 frame restores COL=FE for ROW=7F.
